// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin sharing of the regfile write port plus busy scoreboard
module regfile_wb_arbiter #(
  parameter int WIDTH   = 32,
  parameter int REGBITS = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hold_i,
  input  logic               req0_valid_i,
  input  logic [REGBITS-1:0] req0_addr_i,
  input  logic [WIDTH-1:0]   req0_data_i,
  output logic               req0_ready_o,
  input  logic               req1_valid_i,
  input  logic [REGBITS-1:0] req1_addr_i,
  input  logic [WIDTH-1:0]   req1_data_i,
  output logic               req1_ready_o,
  input  logic               set_i,
  input  logic [REGBITS-1:0] set_addr_i,
  output logic               regwrite_o,
  output logic [REGBITS-1:0] wa_o,
  output logic [WIDTH-1:0]   wd_o,
  output logic [(1<<REGBITS)-1:0] busy_o,
  output logic               err_o
);
  localparam int NREG = 1 << REGBITS;
  logic rr_ptr;
  logic open, contested, grant;
  logic [REGBITS-1:0] g_addr;
  logic [WIDTH-1:0] g_data;
  logic [NREG-1:0] set_mask, clr_mask, busy_nxt;
  // grant selection: single requester wins outright, contention goes to rr_ptr
  always_comb begin
    open = !rst && !hold_i;
    contested = open && req0_valid_i && req1_valid_i;
    req0_ready_o = open && req0_valid_i && (!req1_valid_i || !rr_ptr);
    req1_ready_o = open && req1_valid_i && (!req0_valid_i || rr_ptr);
    grant = req0_ready_o || req1_ready_o;
    g_addr = req1_ready_o ? req1_addr_i : req0_addr_i;
    g_data = req1_ready_o ? req1_data_i : req0_data_i;
    set_mask = set_i ? NREG'(1) << set_addr_i : '0;
    clr_mask = regwrite_o ? NREG'(1) << wa_o : '0;
    busy_nxt = ((busy_o & ~clr_mask) | set_mask) & ~NREG'(1);
  end
  // write port, scoreboard, round-robin pointer and sticky error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regwrite_o <= 1'b0;
      wa_o <= '0;
      wd_o <= '0;
      busy_o <= '0;
      err_o <= 1'b0;
      rr_ptr <= 1'b0;
    end else begin
      regwrite_o <= grant && (g_addr != '0);
      if (grant) begin
        wa_o <= g_addr;
        wd_o <= g_data;
      end
      if (contested) rr_ptr <= !rr_ptr;
      busy_o <= busy_nxt;
      if (grant && g_addr != '0 && !busy_o[g_addr] && !(set_i && set_addr_i == g_addr)) err_o <= 1'b1;
    end
  end
endmodule
